// File: rtl/fpnew_reorder_buffer.sv
// fpnew_reorder_buffer
// Reorder buffer that accepts results out of order from several completion
// channels and hands them back in issue order.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             synchronous clear of every entry (err_o is kept)
//   issue_*             allocation handshake; issue_id_o is the tail index
//                       the next accepted issue will occupy
//   cpl_*               per-channel completions (id, result, status);
//                       cpl_ready_o is always high
//   out_*, result_o,
//   status_o, tag_o     in-order retire handshake driven from the head entry
//   busy_o, count_o     occupancy
//   err_o               sticky flag for illegal or conflicting completions
module fpnew_reorder_buffer #(
  parameter int NumChannels = 4,
  parameter int Depth       = 4,
  parameter int Width       = 64,
  parameter int TagWidth    = 8,
  localparam int IdWidth    = $clog2(Depth)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [TagWidth-1:0]          issue_tag_i,
  output logic [IdWidth-1:0]           issue_id_o,
  input  logic [NumChannels-1:0]       cpl_valid_i,
  output logic [NumChannels-1:0]       cpl_ready_o,
  input  logic [NumChannels*IdWidth-1:0] cpl_id_i,
  input  logic [NumChannels*Width-1:0] cpl_result_i,
  input  logic [NumChannels*5-1:0]     cpl_status_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Width-1:0]             result_o,
  output logic [4:0]                   status_o,
  output logic [TagWidth-1:0]          tag_o,
  output logic                         busy_o,
  output logic [IdWidth:0]             count_o,
  output logic                         err_o
);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [IdWidth:0]    r_head;
  logic [IdWidth:0]    r_tail;
  logic [Depth-1:0]    r_valid;
  logic [Depth-1:0]    r_done;
  logic [TagWidth-1:0] r_tag    [Depth];
  logic [Width-1:0]    r_result [Depth];
  logic [4:0]          r_status [Depth];
  logic                r_err;

  logic [IdWidth-1:0]     w_head_idx;
  logic [IdWidth-1:0]     w_tail_idx;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_issue;
  logic                   w_retire;
  logic [IdWidth-1:0]     w_cpl_id [NumChannels];
  logic [NumChannels-1:0] w_cpl_ok;
  logic                   w_cpl_err;

  assign w_head_idx = r_head[IdWidth-1:0];
  assign w_tail_idx = r_tail[IdWidth-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IdWidth] != r_tail[IdWidth]);
  // Full is judged on registered pointers only: a retire this cycle does
  // not open a slot for an issue in the same cycle.
  assign w_issue    = issue_valid_i && !w_full;
  assign w_retire   = out_valid_o && out_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < NumChannels; gi++) begin : g_cpl_id
      assign w_cpl_id[gi] = cpl_id_i[gi*IdWidth +: IdWidth];
    end
  endgenerate

  // A completion is taken only if its entry was allocated and still pending
  // at the start of the cycle, and no lower-numbered channel claims the same
  // id this cycle. The tail entry being allocated now is not yet valid, so
  // completions aimed at it are rejected by the same test.
  always_comb begin
    w_cpl_ok  = '0;
    w_cpl_err = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (cpl_valid_i[c]) begin
        w_cpl_ok[c] = r_valid[w_cpl_id[c]] && !r_done[w_cpl_id[c]];
        for (int k = 0; k < c; k++) begin
          if (cpl_valid_i[k] && (w_cpl_id[k] == w_cpl_id[c])) begin
            w_cpl_ok[c] = 1'b0;
          end
        end
        if (!w_cpl_ok[c]) begin
          w_cpl_err = 1'b1;
        end
      end
    end
  end

  // Control state. Issue, completion and retire never touch the same entry
  // in one cycle (tail is invalid, a retiring head is already done), so the
  // update order below does not matter; flush overrides them all.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_cpl_err) begin
        r_err <= 1'b1;
      end
      if (flush_i) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_valid <= '0;
        r_done  <= '0;
      end else begin
        for (int c = 0; c < NumChannels; c++) begin
          if (w_cpl_ok[c]) begin
            r_done[w_cpl_id[c]] <= 1'b1;
          end
        end
        if (w_issue) begin
          r_valid[w_tail_idx] <= 1'b1;
          r_done[w_tail_idx]  <= 1'b0;
          r_tail              <= r_tail + (IdWidth+1)'(1);
        end
        if (w_retire) begin
          r_valid[w_head_idx] <= 1'b0;
          r_done[w_head_idx]  <= 1'b0;
          r_head              <= r_head + (IdWidth+1)'(1);
        end
      end
    end
  end

  // Payload storage needs no reset: it is only visible through the gated
  // outputs below once the owning entry is valid (tag) or done (result).
  always_ff @(posedge clk_i) begin
    if (w_issue) begin
      r_tag[w_tail_idx] <= issue_tag_i;
    end
    for (int c = 0; c < NumChannels; c++) begin
      if (w_cpl_ok[c]) begin
        r_result[w_cpl_id[c]] <= cpl_result_i[c*Width +: Width];
        r_status[w_cpl_id[c]] <= cpl_status_i[c*5 +: 5];
      end
    end
  end

  assign issue_ready_o = !w_full;
  assign issue_id_o    = w_tail_idx;
  assign cpl_ready_o   = '1;
  assign out_valid_o   = !w_empty && r_done[w_head_idx];
  assign tag_o         = r_valid[w_head_idx] ? r_tag[w_head_idx] : '0;
  assign result_o      = out_valid_o ? r_result[w_head_idx] : '0;
  assign status_o      = out_valid_o ? r_status[w_head_idx] : '0;
  assign busy_o        = !w_empty;
  assign count_o       = r_tail - r_head;
  assign err_o         = r_err;

endmodule

// File: doc/fpnew_reorder_buffer.md
FPNEW_REORDER_BUFFER -- requirements
Module: fpnew_reorder_buffer

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of out-of-order completion channels (one per operation group).
REQ-002 SHALL have parameter Depth, default 4, number of in-flight entries; a power of two, at least 2.
REQ-003 SHALL have parameter Width, default 64, result width in bits.
REQ-004 SHALL have parameter TagWidth, default 8, width of the opaque tag carried from issue to retire.
REQ-005 SHALL derive IdWidth = clog2(Depth) internally; it is not user-settable.
REQ-006 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port flush_i, input, 1, synchronous clear of all entries.
REQ-009 SHALL have ports issue_valid_i (input, 1), issue_ready_o (output, 1) and issue_tag_i (input, TagWidth): the allocation handshake.
REQ-010 SHALL have port issue_id_o, output, IdWidth, entry index allocated on an issue handshake.
REQ-011 SHALL have ports cpl_valid_i (input, NumChannels), cpl_ready_o (output, NumChannels), cpl_id_i (input, NumChannels x IdWidth), cpl_result_i (input, NumChannels x Width) and cpl_status_i (input, NumChannels x 5): per-channel completions.
REQ-012 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), result_o (output, Width), status_o (output, 5) and tag_o (output, TagWidth): the in-order retire handshake.
REQ-013 SHALL have outputs busy_o (1, high when any entry is allocated), count_o (IdWidth+1, allocated entries) and err_o (1, sticky protocol error).

Function
REQ-014 SHALL hold a circular buffer of Depth entries; each entry holds valid, done, tag, result and status.
REQ-015 SHALL track head and tail pointers of IdWidth+1 bits: empty when equal; full when the indices match and the MSBs differ.
REQ-016 SHALL drive issue_ready_o = not full, independent of issue_valid_i; a retire in the same cycle SHALL NOT bypass a full condition.
REQ-017 SHALL drive issue_id_o = tail index continuously.
REQ-018 SHALL, on issue_valid_i and issue_ready_o, set the tail entry valid=1, done=0, store issue_tag_i and increment tail modulo 2*Depth.
REQ-019 SHALL tie cpl_ready_o to all ones; storage is pre-reserved, so completions never stall.
REQ-020 SHALL, on cpl_valid_i[c], write cpl_result_i[c] and cpl_status_i[c] into entry cpl_id_i[c] and set done=1, but only if that entry was valid and not done at the start of the cycle.
REQ-021 SHALL ignore any completion to a not-valid entry, an already-done entry, or an entry allocated in the same cycle, and SHALL set err_o.
REQ-022 SHALL, when two or more channels target the same id in one cycle, let the lowest channel index win; the other channels SHALL be ignored and SHALL set err_o.
REQ-023 SHALL accept completions to distinct ids on all channels in the same cycle.
REQ-024 SHALL drive out_valid_o = not empty and head entry done.
REQ-025 SHALL drive result_o, status_o and tag_o from the head entry combinationally.
REQ-026 SHALL present a completion no earlier than one cycle after it is written; there is no completion-to-output bypass.
REQ-027 SHALL, on out_valid_o and out_ready_i, clear the head entry's valid and done bits and increment head.
REQ-028 SHALL hold out_valid_o and the output data stable while out_ready_i is low.
REQ-029 SHALL retire strictly in issue order, regardless of completion order.
REQ-030 SHALL support issue, completions and retire in the same cycle; count_o changes by +1, 0 or -1 accordingly.
REQ-031 SHALL allow a completion to the head entry in the same cycle as the head retires only if it targets a different id (per REQ-021).
REQ-032 SHALL handle pointer wrap-around with no bubble at the Depth boundary.
REQ-033 SHALL give flush_i priority over issue, completion and retire in the same cycle: clear all valid/done bits and zero head and tail; empty from the next cycle.
REQ-034 SHALL NOT clear err_o on flush; only reset clears it.

Reset
REQ-035 SHALL, while rst_ni is low, asynchronously set head=tail=0, all valid/done=0 and err_o=0.
REQ-036 SHALL therefore drive out_valid_o=0, busy_o=0, count_o=0, issue_ready_o=1 and issue_id_o=0 in reset.
REQ-037 SHALL drive result_o=0, status_o=0 and tag_o=0 in reset.
REQ-038 SHALL discard in-flight entries without retiring them when reset is asserted mid-operation.

Verification
REQ-039 SHALL cover in-order completion, Depth=4: issue tags 1,2,3 (ids 0,1,2); complete each on channel 0 one cycle later -> retires tags 1,2,3 in order; latency one cycle from completion to out_valid_o.
REQ-040 SHALL cover reordering: issue tags A,B,C; complete id2, then id0, then id1 on channels 3, 1, 2 -> out_valid_o rises after id0 completes; retire order A,B,C; out_valid_o drops after A until id1 completes.
REQ-041 SHALL cover full/wrap: issue 4 with out_ready_i=0 -> issue_ready_o=0 and count_o=4; retire 1 and issue in the same cycle -> issue not accepted; the following cycle the issue gets id0 with wrap and no bubble.
REQ-042 SHALL cover errors: complete id 3 while empty -> ignored, err_o=1; two channels complete id 0 in one cycle -> channel 0's data retires, err_o=1.
REQ-043 SHALL cover flush and reset: with 3 entries (1 done), assert flush_i together with an issue -> next cycle count_o=0, out_valid_o=0, err_o unchanged; rst_ni low mid-stream -> all outputs immediately take their reset values.
